// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: digit-serial WIDTH-bit adder built around a single
// 4-bit carry-lookahead adder. Operands are consumed one nibble per cycle,
// LSB nibble first, with the nibble carry held in c_reg between cycles.
// Latency is WIDTH/4 cycles from the accepted start to the done pulse.
// WIDTH must be a multiple of 4 and at least 8.
//
// Optional feature macro: NIBBLE_SERIAL_ADD_OVF_EN
//   defined   -> extra output 'ovf' (two's-complement signed overflow)
//   undefined -> no ovf port and no overflow logic

module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    output logic       c3,
`endif
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Per-bit generate/propagate and sum bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign g[gi]   = a[gi] & b[gi];
            assign p[gi]   = a[gi] ^ b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Flattened lookahead carries, each a two-level function of g/p/cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign cout = c[4];
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    // Carry into bit 3; combined with cout it gives signed overflow.
    assign c3 = c[3];
`endif
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [3:0]       cla_sum;
    logic             cla_cout;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic             cla_c3;
    logic             ovf_reg;
`endif

    // The single shared 4-bit adder always works on the current low nibbles.
    cla u_cla (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (c_reg),
        .sum  (cla_sum),
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        .c3   (cla_c3),
`endif
        .cout (cla_cout)
    );

    // Control FSM plus the nibble datapath: load on start, shift per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            c_reg     <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh      <= op_a;
                        b_sh      <= op_b;
                        c_reg     <= cin;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= {4'b0000, a_sh[WIDTH-1:4]};
                    b_sh    <= {4'b0000, b_sh[WIDTH-1:4]};
                    c_reg   <= cla_cout;
                    cnt_reg <= cnt_reg + 1'b1;
                    // New nibble enters at the top; after N shifts nibble 0 sits at the bottom.
                    sum_reg <= {cla_sum, sum_reg[WIDTH-1:4]};
                    if (cnt_reg == LAST) begin
                        cout_reg  <= cla_cout;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
                        ovf_reg   <= cla_c3 ^ cla_cout;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    assign ovf  = ovf_reg;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: directed vectors on a 16-bit instance,
// plus random vectors on 16- and 8-bit instances against a+b+cin.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 16-bit instance
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic        ovf16;
`endif

    // 8-bit instance
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic        ovf8;
`endif

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .op_a  (a16),
        .op_b  (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        .ovf   (ovf16),
`endif
        .cout  (cout16)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .op_a  (a8),
        .op_b  (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        .ovf   (ovf8),
`endif
        .cout  (cout8)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on dut16, returning the number of edges waited (bounded).
    task automatic wait_done16(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done16 && n < 20);
    endtask

    // One 16-bit add from the sample point; checks latency, pulse and result.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] exp_s, input logic exp_co);
        int n;
        a16 = a; b16 = b; cin16 = ci; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        check_eq({tag, ".busy"}, 64'(busy16), 64'd1);
        wait_done16(n);
        check_eq({tag, ".lat"}, 64'(n), 64'd4);
        check_eq({tag, ".busy_at_done"}, 64'(busy16), 64'd0);
        check_eq({tag, ".sum"}, 64'(sum16), 64'(exp_s));
        check_eq({tag, ".cout"}, 64'(cout16), 64'(exp_co));
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        check_eq({tag, ".ovf"}, 64'(ovf16),
                 64'((a[15] == b[15]) && (exp_s[15] != a[15])));
`endif
        $display("add16 %s: %h + %h + %0d -> cout=%0d sum=%h lat=%0d", tag, a, b, ci, cout16, sum16, n);
        tick();
        check_eq({tag, ".done_pulse"}, 64'(done16), 64'd0);
        check_eq({tag, ".sum_hold"}, 64'(sum16), 64'(exp_s));
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
        int n;
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + 9'(ci);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done8 && n < 20);
        check_eq({tag, ".lat"}, 64'(n), 64'd2);
        check_eq({tag, ".res"}, 64'({cout8, sum8}), 64'(r));
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        check_eq({tag, ".ovf"}, 64'(ovf8), 64'((a[7] == b[7]) && (r[7] != a[7])));
`endif
        $display("add8 %s: %h + %h + %0d -> cout=%0d sum=%h lat=%0d", tag, a, b, ci, cout8, sum8, n);
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rr;

        // Reset
        tick(); tick();
        rst = 1'b0;
        check_eq("rst.busy", 64'(busy16), 64'd0);
        check_eq("rst.done", 64'(done16), 64'd0);
        check_eq("rst.sum", 64'(sum16), 64'd0);
        check_eq("rst.cout", 64'(cout16), 64'd0);
        check_eq("rst8.res", 64'({busy8, done8, cout8, sum8}), 64'd0);
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        check_eq("rst.ovf", 64'(ovf16), 64'd0);
`endif
        $display("reset: busy=%0d done=%0d sum=%h cout=%0d", busy16, done16, sum16, cout16);

        // Basic and full-ripple carries
        run16("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run16("ripple_b", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run16("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

        // start during RUN is ignored and not queued
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick(); tick();
        a16 = 16'hAAAA; b16 = 16'h5555; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        check_eq("ign.busy", 64'(busy16), 64'd1);
        tick();
        check_eq("ign.done", 64'(done16), 64'd1);
        check_eq("ign.sum", 64'(sum16), 64'h3333);
        tick();
        check_eq("ign.not_queued", 64'(busy16), 64'd0);
        $display("ignored start: sum=%h busy_after=%0d", sum16, busy16);

        // start held through done launches the next add
        a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0; start16 = 1'b1;
        tick();
        wait_done16(n);
        check_eq("held1.lat", 64'(n), 64'd4);
        check_eq("held1.sum", 64'(sum16), 64'h1010);
        a16 = 16'hFFFF; b16 = 16'h0002;
        tick();
        start16 = 1'b0;
        check_eq("held2.busy", 64'(busy16), 64'd1);
        wait_done16(n);
        check_eq("held2.lat", 64'(n), 64'd4);
        check_eq("held2.sum", 64'(sum16), 64'h0001);
        check_eq("held2.cout", 64'(cout16), 64'd1);
        $display("held start: second sum=%h cout=%0d lat=%0d", sum16, cout16, n);
        tick();

        // Reset mid-operation aborts with no done
        a16 = 16'hAAAA; b16 = 16'h1111; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check_eq("abort.busy", 64'(busy16), 64'd0);
        check_eq("abort.done", 64'(done16), 64'd0);
        check_eq("abort.sum", 64'(sum16), 64'd0);
        check_eq("abort.cout", 64'(cout16), 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done16) seen++;
        end
        check_eq("abort.no_done", 64'(seen), 64'd0);
        $display("abort: done pulses after reset=%0d", seen);
        run16("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0);

`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        run16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        check_eq("ovf_pos.flag", 64'(ovf16), 64'd1);
        run16("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        check_eq("ovf_neg.flag", 64'(ovf16), 64'd1);
        run16("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        check_eq("ovf_none.flag", 64'(ovf16), 64'd0);
`endif

        // Random sweeps
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            rr = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            run16("rnd16", ra, rb, rc, rr[15:0], rr[16]);
        end
        run8("edge8_max", 8'hFF, 8'hFF, 1'b1);
        run8("edge8_zero", 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            run8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
